// File: rtl/threshold_monitor_if.sv
// Sample/threshold/result bundle between the sampling front end and threshold_monitor.
// THRESH_STICKY_EN adds the sticky alarm flags and their clear strobe.
interface threshold_monitor_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      sample_valid;
  logic [WIDTH*CHANNELS-1:0] in_bus;
  logic [WIDTH-1:0]          thr_high;
  logic [WIDTH-1:0]          thr_low;
  logic [CHANNELS-1:0]       out;
  logic                      any_out;
`ifdef THRESH_STICKY_EN
  logic                      alarm_clr;
  logic [CHANNELS-1:0]       alarm;

  modport master (
    output sample_valid, in_bus, thr_high, thr_low, alarm_clr,
    input  out, any_out, alarm
  );
  modport slave (
    input  sample_valid, in_bus, thr_high, thr_low, alarm_clr,
    output out, any_out, alarm
  );
`else
  modport master (
    output sample_valid, in_bus, thr_high, thr_low,
    input  out, any_out
  );
  modport slave (
    input  sample_valid, in_bus, thr_high, thr_low,
    output out, any_out
  );
`endif
endinterface

// File: rtl/threshold_monitor.sv
// Per-channel hysteresis threshold detector with DEBOUNCE-sample debounce; out registered, any_out = |out.
// Optional macro THRESH_STICKY_EN adds sticky per-channel rise alarms with a clear strobe.
module threshold_monitor #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 4
) (
  input logic              clk,
  input logic              rst,
  threshold_monitor_if.slave mon
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_CNT = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [WIDTH-1:0]    sample  [CHANNELS];
  logic [CHANNELS-1:0] above;
  logic [CHANNELS-1:0] below;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;

  // Strict unsigned compares: a sample equal to a threshold qualifies as neither.
  always_comb begin
    above = '0;
    below = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sample[k] = mon.in_bus[k*WIDTH +: WIDTH];
      above[k]  = sample[k] > mon.thr_high;
      below[k]  = sample[k] < mon.thr_low;
    end
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (mon.sample_valid) begin
        case (state_q[k])
          LOW: begin
            if (above[k]) begin
              if (DEBOUNCE == 1) begin
                state_d[k] = HIGH;
                cnt_d[k]   = '0;
              end else begin
                state_d[k] = RISE_PEND;
                cnt_d[k]   = CW'(1);
              end
            end
          end
          RISE_PEND: begin
            if (!above[k]) begin
              state_d[k] = LOW;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] + CW'(1) == DB_CNT) begin
              state_d[k] = HIGH;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k]   = cnt_q[k] + CW'(1);
            end
          end
          HIGH: begin
            if (below[k]) begin
              if (DEBOUNCE == 1) begin
                state_d[k] = LOW;
                cnt_d[k]   = '0;
              end else begin
                state_d[k] = FALL_PEND;
                cnt_d[k]   = CW'(1);
              end
            end
          end
          FALL_PEND: begin
            if (!below[k]) begin
              state_d[k] = HIGH;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] + CW'(1) == DB_CNT) begin
              state_d[k] = LOW;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k]   = cnt_q[k] + CW'(1);
            end
          end
          default: begin
            state_d[k] = LOW;
            cnt_d[k]   = '0;
          end
        endcase
      end
      // Output is registered from next state so it flips on the qualifying edge itself.
      out_d[k] = (state_d[k] == HIGH) || (state_d[k] == FALL_PEND);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= LOW;
        cnt_q[k]   <= '0;
      end
      out_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      out_q <= out_d;
    end
  end

  assign mon.out     = out_q;
  assign mon.any_out = |out_q;

`ifdef THRESH_STICKY_EN
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] alarm_q;
  logic [CHANNELS-1:0] alarm_d;

  // A rise on the same edge as a clear keeps its flag.
  always_comb begin
    rise    = out_d & ~out_q;
    alarm_d = (alarm_q & ~{CHANNELS{mon.alarm_clr}}) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign mon.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_threshold_monitor.sv
// Scoreboard bench for threshold_monitor: directed scenarios followed by randomized samples near the thresholds.
module tb_threshold_monitor;
  localparam int W = 16;
  localparam int C = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  threshold_monitor_if #(.WIDTH(W), .CHANNELS(C)) bus_if ();

  threshold_monitor #(.WIDTH(W), .CHANNELS(C), .DEBOUNCE(D)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus_if)
  );

  typedef struct packed {
    logic [C-1:0] out;
    logic         any;
    logic [C-1:0] alarm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: per channel, the debounced level plus the length of the
  // current run of samples that argue for the opposite level.
  bit           m_out [C];
  int           m_run [C];
  logic [C-1:0] m_alarm;
  int           th = 1000;
  int           tl = 900;

  task automatic model_reset();
    for (int k = 0; k < C; k++) begin
      m_out[k] = 1'b0;
      m_run[k] = 0;
    end
    m_alarm = '0;
  endtask

  task automatic model_step(input logic [W*C-1:0] b, input logic clr, output exp_t e);
    logic [C-1:0] rises;
    int v;
    rises = '0;
    for (int k = 0; k < C; k++) begin
      v = int'(b[k*W +: W]);
      if (!m_out[k]) begin
        m_run[k] = (v > th) ? m_run[k] + 1 : 0;
        if (m_run[k] == D) begin
          m_out[k] = 1'b1;
          m_run[k] = 0;
          rises[k] = 1'b1;
        end
      end else begin
        m_run[k] = (v < tl) ? m_run[k] + 1 : 0;
        if (m_run[k] == D) begin
          m_out[k] = 1'b0;
          m_run[k] = 0;
        end
      end
    end
`ifdef THRESH_STICKY_EN
    m_alarm = (clr ? '0 : m_alarm) | rises;
`else
    m_alarm = '0;
    if (clr && rises != '0) m_alarm = '0;
`endif
    for (int k = 0; k < C; k++) e.out[k] = m_out[k];
    e.any   = |e.out;
    e.alarm = m_alarm;
  endtask

  function automatic logic [W*C-1:0] mk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic send(input logic v, input logic [W*C-1:0] b, input logic clr);
    exp_t e;
    @(negedge clk);
    bus_if.sample_valid = v;
    bus_if.in_bus       = b;
    bus_if.thr_high     = W'(th);
    bus_if.thr_low      = W'(tl);
`ifdef THRESH_STICKY_EN
    bus_if.alarm_clr    = clr;
`endif
    if (v) begin
      model_step(b, clr, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic rep(input int n, input logic [W*C-1:0] b);
    for (int i = 0; i < n; i++) send(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, 1'b0);
  endtask

  function automatic logic [C-1:0] act_alarm();
`ifdef THRESH_STICKY_EN
    return bus_if.alarm;
`else
    return '0;
`endif
  endfunction

  task automatic chk_zero(input string name);
    checks++;
    if (bus_if.out !== '0 || bus_if.any_out !== 1'b0 || act_alarm() !== '0) begin
      failures++;
      $display("FAIL %s: out=%b any_out=%b alarm=%b, required all zero",
               name, bus_if.out, bus_if.any_out, act_alarm());
    end
  endtask

  // Monitor: every valid sample edge produces one observable result.
  initial begin
    logic v;
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      v = bus_if.sample_valid && !rst;
      @(negedge clk);
      if (v) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: result seen with no expectation queued");
        end else begin
          e       = exp_q.pop_front();
          a.out   = bus_if.out;
          a.any   = bus_if.any_out;
          a.alarm = act_alarm();
          if (a !== e) begin
            failures++;
            $display("FAIL sample_result t=%0t: out=%b any=%b alarm=%b, required out=%b any=%b alarm=%b",
                     $time, a.out, a.any, a.alarm, e.out, e.any, e.alarm);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.sample_valid = 1'b0;
    bus_if.in_bus       = '0;
    bus_if.thr_high     = W'(th);
    bus_if.thr_low      = W'(tl);
`ifdef THRESH_STICKY_EN
    bus_if.alarm_clr    = 1'b0;
`endif
    model_reset();
    #1 rst = 1'b1;
    #2 chk_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Equality never qualifies; 1001 x4 rises on the 4th valid edge.
    rep(5, mk(1000, 0, 0, 0));
    rep(4, mk(1001, 0, 0, 0));

    // Glitch on ch1 restarts its run.
    send(1'b1, mk(950, 1001, 0, 0), 1'b0);
    send(1'b1, mk(950, 1001, 0, 0), 1'b0);
    send(1'b1, mk(950, 1001, 0, 0), 1'b0);
    send(1'b1, mk(950, 950,  0, 0), 1'b0);
    rep(4, mk(950, 1001, 0, 0));

    // ch2 rise, hold in band, interrupted fall, full fall.
    rep(4,  mk(950, 950, 1001, 0));
    rep(20, mk(950, 950, 950,  0));
    rep(3,  mk(950, 950, 899,  0));
    send(1'b1, mk(950, 950, 900, 0), 1'b0);
    rep(4,  mk(950, 950, 899,  0));

    // ch3 rise across gaps; invalid cycles carry values that would break the run.
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 3 || i == 5 || i == 9) send(1'b1, mk(950, 950, 950, 1001), 1'b0);
      else                                       send(1'b0, mk(950, 950, 950, 0),    1'b0);
    end

    // Drop ch0, then clear alarms on the very edge ch0 rises again.
    rep(4, mk(899, 950, 950, 950));
    rep(3, mk(1001, 950, 950, 950));
    send(1'b1, mk(1001, 950, 950, 950), 1'b1);

    // Asynchronous reset between edges while ch0 is high.
    idle(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rep(3, mk(1001, 0, 0, 0));

    // Partial run discarded by reset.
    idle(2);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 chk_zero("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    rep(3, mk(1001, 0, 0, 0));
    rep(1, mk(1001, 0, 0, 0));

    // Random samples clustered around randomly moving thresholds.
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic clr;
      if ($urandom_range(0, 15) == 0) begin
        th = $urandom_range(900, 1000);
        tl = $urandom_range(880, 1010);
      end
      v   = ($urandom_range(0, 3) != 0);
      clr = v && ($urandom_range(0, 19) == 0);
      send(v, mk($urandom_range(880, 1020), $urandom_range(880, 1020),
                 $urandom_range(880, 1020), $urandom_range(880, 1020)), clr);
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
